uart_tx_fifo: RTL and testbench

Parametrised UART transmitter with an integrated transmit FIFO, runtime-selectable baud divisor, parity and stop-bit count. It is the next generation of the single-byte `tx_start`/`tx_busy` transmitter used around the Caravel user project. It sits between a byte producer (Wishbone/LA-facing register logic or DMA) and the `ser_tx` pin routed to `mprj_io[6]`. It replaces the one-byte start/busy handshake with a valid/ready FIFO interface, so firmware can queue bursts.

---
 rtl/uart_tx_fifo.sv | 204 ++++++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a circular-buffer FIFO.
// Divisor, parity mode and stop-bit count are captured per frame when the head byte is popped.
module uart_tx_fifo #(
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int DIV_WIDTH  = 16
) (
    input  logic                                clock,
    input  logic                                RSTB,
    input  logic [DIV_WIDTH-1:0]                clk_div,
    input  logic [1:0]                          parity_mode,
    input  logic                                stop2,
    input  logic                                in_valid,
    input  logic [DATA_BITS-1:0]                in_data,
    output logic                                in_ready,
    input  logic                                tx_clear_req,
    output logic                                ser_tx,
    output logic                                tx_busy,
    output logic                                tx_done,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]     fifo_count
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int BW = $clog2(DATA_BITS);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_e;

    state_e                 state_q, state_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic                   par_q, par_d;
    logic [DIV_WIDTH-1:0]   timer_q, timer_d;
    logic [DIV_WIDTH-1:0]   div_q, div_d;
    logic [1:0]             mode_q, mode_d;
    logic                   stop2_q, stop2_d;
    logic [BW-1:0]          bit_q, bit_d;
    logic                   stop_cnt_q, stop_cnt_d;
    logic                   ser_tx_q, ser_tx_d;

    logic [PW-1:0]          wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]          rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]          count_q, count_d;
    logic [DATA_BITS-1:0]   mem_q [FIFO_DEPTH];

    logic push, pop, load, can_pop, bit_end, parity_en;

    assign in_ready   = (count_q != CW'(FIFO_DEPTH)) && !tx_clear_req;
    assign push       = in_valid && in_ready;
    // A flush in progress must never hand stale data to the serialiser.
    assign can_pop    = (count_q != '0) && !tx_clear_req;
    assign bit_end    = (timer_q == '0);
    assign parity_en  = (mode_q == 2'b01) || (mode_q == 2'b10);
    assign tx_busy    = (state_q != S_IDLE) || (count_q != '0);
    assign ser_tx     = ser_tx_q;
    assign fifo_count = count_q;

    always_comb begin
        // NOTE: every variable gets a default before any branch so no path leaves it unassigned (no latches).
        state_d    = state_q;
        shift_d    = shift_q;
        par_d      = par_q;
        timer_d    = timer_q;
        div_d      = div_q;
        mode_d     = mode_q;
        stop2_d    = stop2_q;
        bit_d      = bit_q;
        stop_cnt_d = stop_cnt_q;
        ser_tx_d   = 1'b1;
        tx_done    = 1'b0;
        load       = 1'b0;

        if (state_q != S_IDLE) begin
            timer_d = bit_end ? div_q : timer_q - DIV_WIDTH'(1);
        end

        case (state_q)
            S_IDLE: begin
                if (can_pop) load = 1'b1;
            end
            S_START: begin
                if (bit_end) begin
                    state_d = S_DATA;
                    bit_d   = '0;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    par_d   = par_q ^ shift_q[0];
                    shift_d = shift_q >> 1;
                    if (bit_q == LAST_BIT) begin
                        state_d    = parity_en ? S_PARITY : S_STOP;
                        stop_cnt_d = 1'b0;
                    end else begin
                        bit_d = bit_q + BW'(1);
                    end
                end
            end
            S_PARITY: begin
                if (bit_end) begin
                    state_d    = S_STOP;
                    stop_cnt_d = 1'b0;
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    if (stop_cnt_q == stop2_q) begin
                        tx_done = 1'b1;
                        if (can_pop) load = 1'b1;
                        else         state_d = S_IDLE;
                    end else begin
                        stop_cnt_d = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Frame start: config is taken from the live inputs, then held for the whole frame.
        if (load) begin
            state_d = S_START;
            shift_d = mem_q[rd_ptr_q];
            par_d   = 1'b0;
            div_d   = clk_div;
            timer_d = clk_div;
            mode_d  = parity_mode;
            stop2_d = stop2;
        end

        // The line is registered, so it is driven from the state being entered.
        case (state_d)
            S_START:  ser_tx_d = 1'b0;
            S_DATA:   ser_tx_d = shift_d[0];
            S_PARITY: ser_tx_d = par_d ^ (mode_d == 2'b10);
            default:  ser_tx_d = 1'b1;
        endcase
    end

    assign pop = load;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (tx_clear_req) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // NOTE: storage is not reset; the pointers and count alone decide which entries are valid.
    always_ff @(posedge clock) begin
        if (push) mem_q[wr_ptr_q] <= in_data;
    end

    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clock) begin
        if (!RSTB) begin
            state_q    <= S_IDLE;
            shift_q    <= '0;
            par_q      <= 1'b0;
            timer_q    <= '0;
            div_q      <= '0;
            mode_q     <= 2'b00;
            stop2_q    <= 1'b0;
            bit_q      <= '0;
            stop_cnt_q <= 1'b0;
            ser_tx_q   <= 1'b1;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            par_q      <= par_d;
            timer_q    <= timer_d;
            div_q      <= div_d;
            mode_q     <= mode_d;
            stop2_q    <= stop2_d;
            bit_q      <= bit_d;
            stop_cnt_q <= stop_cnt_d;
            ser_tx_q   <= ser_tx_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: table of single frames from idle plus burst, flush,
// reset and divisor-change sequences. Inputs change and outputs are sampled on the falling edge.
module tb_uart_tx_fifo;

    localparam int DB = 8;
    localparam int FD = 16;
    localparam int DW = 16;
    localparam int CW = $clog2(FD + 1);

    logic            clock = 1'b0;
    logic            RSTB;
    logic [DW-1:0]   clk_div;
    logic [1:0]      parity_mode;
    logic            stop2;
    logic            in_valid;
    logic [DB-1:0]   in_data;
    logic            in_ready;
    logic            tx_clear_req;
    logic            ser_tx;
    logic            tx_busy;
    logic            tx_done;
    logic [CW-1:0]   fifo_count;

    int checks = 0;
    int errors = 0;
    int done_pulses;
    int stray;

    typedef struct {
        string         name;
        logic [7:0]    data;
        logic [DW-1:0] div;
        logic [1:0]    pmode;
        logic          s2;
        string         bits;
    } vec_t;

    vec_t vecs [6];

    uart_tx_fifo #(.DATA_BITS(DB), .FIFO_DEPTH(FD), .DIV_WIDTH(DW)) dut (
        .clock        (clock),
        .RSTB         (RSTB),
        .clk_div      (clk_div),
        .parity_mode  (parity_mode),
        .stop2        (stop2),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .tx_clear_req (tx_clear_req),
        .ser_tx       (ser_tx),
        .tx_busy      (tx_busy),
        .tx_done      (tx_done),
        .fifo_count   (fifo_count)
    );

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Called at the falling edge before the frame's first cycle; checks every cycle of the frame.
    task automatic expect_frame(input string name, input string bits, input int div);
        for (int i = 0; i < bits.len(); i++) begin
            for (int c = 0; c <= div; c++) begin
                @(negedge clock);
                check($sformatf("%s ser_tx bit%0d cyc%0d", name, i, c), ser_tx, (bits[i] == "1"));
                check($sformatf("%s tx_done bit%0d cyc%0d", name, i, c), tx_done,
                      (i == bits.len() - 1) && (c == div));
                if (tx_done) done_pulses++;
            end
        end
    endtask

    function automatic string plain_frame(input logic [7:0] d);
        string s = "0";
        for (int i = 0; i < 8; i++) s = $sformatf("%s%0d", s, d[i]);
        return $sformatf("%s1", s);
    endfunction

    task automatic push_byte(input logic [7:0] d);
        int budget = 0;
        in_data  = d;
        in_valid = 1'b1;
        while (!in_ready && budget < 200) begin
            @(negedge clock);
            budget++;
        end
        if (budget >= 200) check("push stall bound", 0, 1);
        @(negedge clock);
        in_valid = 1'b0;
    endtask

    initial begin
        vecs[0] = '{"a5_even_s1", 8'hA5, 16'd3, 2'b01, 1'b0, "01010010101"};
        vecs[1] = '{"01_odd_s2",  8'h01, 16'd3, 2'b10, 1'b1, "010000000011"};
        vecs[2] = '{"01_even_s2", 8'h01, 16'd3, 2'b01, 1'b1, "010000000111"};
        vecs[3] = '{"3c_none_d0", 8'h3C, 16'd0, 2'b00, 1'b0, "0001111001"};
        vecs[4] = '{"ff_rsv_s2",  8'hFF, 16'd1, 2'b11, 1'b1, "01111111111"};
        vecs[5] = '{"80_odd_d2",  8'h80, 16'd2, 2'b10, 1'b0, "00000000101"};

        RSTB = 1'b0;
        clk_div = 16'd3;
        parity_mode = 2'b00;
        stop2 = 1'b0;
        in_valid = 1'b0;
        in_data = '0;
        tx_clear_req = 1'b0;
        repeat (3) @(negedge clock);

        check("reset ser_tx", ser_tx, 1);
        check("reset tx_busy", tx_busy, 0);
        check("reset tx_done", tx_done, 0);
        check("reset fifo_count", fifo_count, 0);
        check("reset in_ready", in_ready, 1);
        tx_clear_req = 1'b1;
        #1;
        check("in_ready during clear", in_ready, 0);
        tx_clear_req = 1'b0;
        RSTB = 1'b1;
        @(negedge clock);

        // Single frames from idle.
        for (int v = 0; v < 6; v++) begin
            clk_div     = vecs[v].div;
            parity_mode = vecs[v].pmode;
            stop2       = vecs[v].s2;
            done_pulses = 0;
            push_byte(vecs[v].data);
            check({vecs[v].name, " count after push"}, fifo_count, 1);
            check({vecs[v].name, " busy after push"}, tx_busy, 1);
            check({vecs[v].name, " line idle before pop"}, ser_tx, 1);
            expect_frame(vecs[v].name, vecs[v].bits, int'(vecs[v].div));
            @(negedge clock);
            check({vecs[v].name, " busy after frame"}, tx_busy, 0);
            check({vecs[v].name, " line after frame"}, ser_tx, 1);
            check({vecs[v].name, " done pulses"}, done_pulses, 1);
            check({vecs[v].name, " count after frame"}, fifo_count, 0);
        end

        // Burst of 17 bytes: FIFO fills, frames follow back-to-back in order.
        clk_div = 16'd3;
        parity_mode = 2'b00;
        stop2 = 1'b0;
        done_pulses = 0;
        fork
            begin
                for (int k = 0; k < 17; k++) begin
                    int budget = 0;
                    in_data  = 8'(k);
                    in_valid = 1'b1;
                    while (!in_ready && budget < 200) begin
                        @(negedge clock);
                        budget++;
                    end
                    if (budget >= 200) check("burst push stall bound", 0, 1);
                    @(negedge clock);
                end
                in_valid = 1'b0;
                check("burst count full", fifo_count, 16);
                check("burst in_ready when full", in_ready, 0);
            end
            begin
                @(negedge clock);
                check("burst line idle before pop", ser_tx, 1);
                for (int f = 0; f < 17; f++)
                    expect_frame($sformatf("burst%0d", f), plain_frame(8'(f)), 3);
            end
        join
        @(negedge clock);
        check("burst done pulses", done_pulses, 17);
        check("burst busy after", tx_busy, 0);
        check("burst count after", fifo_count, 0);

        // Flush during frame 1's data bits.
        parity_mode = 2'b01;
        done_pulses = 0;
        stray = 0;
        fork
            begin
                for (int k = 0; k < 5; k++) begin
                    in_data  = 8'h11 + 8'(k);
                    in_valid = 1'b1;
                    @(negedge clock);
                end
                in_valid = 1'b0;
                repeat (3) @(negedge clock);
                check("clear count before", fifo_count, 4);
                in_data = 8'h77;
                in_valid = 1'b1;
                tx_clear_req = 1'b1;
                #1;
                check("clear blocks push", in_ready, 0);
                @(negedge clock);
                tx_clear_req = 1'b0;
                in_valid = 1'b0;
                check("clear count after", fifo_count, 0);
            end
            begin
                @(negedge clock);
                expect_frame("clear_f1", "01000100001", 3);
                repeat (60) begin
                    @(negedge clock);
                    if (tx_done) done_pulses++;
                    if (ser_tx !== 1'b1) stray++;
                end
            end
        join
        check("clear line idle after", stray, 0);
        check("clear done pulses", done_pulses, 1);
        check("clear busy after", tx_busy, 0);

        // Reset during the data bits, then a normal frame.
        parity_mode = 2'b00;
        push_byte(8'hC3);
        push_byte(8'h5A);
        repeat (6) @(negedge clock);
        RSTB = 1'b0;
        @(negedge clock);
        check("midreset ser_tx", ser_tx, 1);
        check("midreset fifo_count", fifo_count, 0);
        check("midreset tx_busy", tx_busy, 0);
        check("midreset tx_done", tx_done, 0);
        RSTB = 1'b1;
        @(negedge clock);
        check("post reset idle busy", tx_busy, 0);
        done_pulses = 0;
        push_byte(8'h3C);
        check("post reset count", fifo_count, 1);
        expect_frame("post_reset", "0001111001", 3);
        @(negedge clock);
        check("post reset done pulses", done_pulses, 1);
        check("post reset busy after", tx_busy, 0);

        // Divisor changes mid-frame: only the next frame uses the new value.
        clk_div = 16'd3;
        done_pulses = 0;
        fork
            begin
                in_data = 8'hA5;
                in_valid = 1'b1;
                @(negedge clock);
                in_data = 8'h5A;
                @(negedge clock);
                in_valid = 1'b0;
                repeat (2) @(negedge clock);
                clk_div = 16'd7;
            end
            begin
                @(negedge clock);
                expect_frame("div3", "0101001011", 3);
                expect_frame("div7", "0010110101", 7);
            end
        join
        @(negedge clock);
        check("div change done pulses", done_pulses, 2);
        check("div change busy after", tx_busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
